// File: rtl/add_serial_pkg.sv
// rtl/add_serial_pkg.sv - shared constants, FSM encoding and helpers for the serial-adder scheduler
//
// Purpose : state encoding, default sizing constants and a constant-evaluable clog2.
// Ports   : none (package).
package add_serial_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_ADD_LATENCY = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  // Minimum result is 1 so that single-entry ranges still get a usable field width.
  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/add_serial_rr_sched_rr_pick.sv
// rtl/add_serial_rr_sched_rr_pick.sv - combinational round-robin picker
//
// Purpose : finds the first set request bit, searching upward from i_last_id+1 with wrap.
// Ports   : i_req      requests, one bit per requester
//           i_last_id  index of the most recently served requester
//           o_winner   selected index (0 when nothing found)
//           o_found    a request was found
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_id,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_found
);

  int w_idx;

  // The last-served index is visited last, giving it the lowest priority.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(i_last_id) + k) % NUM_REQ;
      if (!o_found && i_req[w_idx]) begin
        o_found  = 1'b1;
        o_winner = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/add_serial_rr_sched.sv
// rtl/add_serial_rr_sched.sv - round-robin scheduler sharing one bit-serial adder
//
// Purpose : arbitrates NUM_REQ requesters onto a single shared serial adder, sequences its
//           enable for ADD_LATENCY+1 cycles and returns the sum with a one-cycle strobe.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           req             per-requester request level
//           a_in, b_in      packed operands, slice i belongs to requester i
//           resp_valid      one-hot result strobe
//           resp_sum        result, held between strobes
//           grant_id        requester currently being served
//           busy            operation in progress (START/WAIT/DELIVER)
//           op_count        completed operations, wrapping
//           add_en          shared adder enable
//           add_a, add_b    registered adder operands
//           add_out         shared adder result
module add_serial_rr_sched
  import add_serial_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADD_LATENCY = DEF_ADD_LATENCY,
  parameter int ID_W        = clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_sum,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic [15:0]              op_count,
  output logic                     add_en,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_out
);

  localparam int CNT_W = clog2(ADD_LATENCY);

  state_t             r_state;
  state_t             w_next_state;
  logic [ID_W-1:0]    r_last_id;
  logic [ID_W-1:0]    r_grant_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;
  logic [WIDTH-1:0]   r_resp_sum;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [15:0]        r_op_count;

  logic [ID_W-1:0]    w_winner;
  logic               w_found;
  logic               w_load;
  logic               w_deliver;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req     (req),
    .i_last_id (r_last_id),
    .o_winner  (w_winner),
    .o_found   (w_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // add_en is decoded from state so an asynchronous reset removes it immediately.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_deliver    = 1'b0;
    add_en       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_load       = 1'b1;
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        add_en       = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        add_en = 1'b1;
        if (r_cnt == CNT_W'(ADD_LATENCY - 1)) begin
          w_deliver    = 1'b1;
          w_next_state = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        // add_en low here lets the adder fall back from done to idle.
        if (w_found) begin
          w_load       = 1'b1;
          w_next_state = ST_START;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_id    <= ID_W'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_cnt        <= '0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_resp_sum   <= '0;
      r_resp_valid <= '0;
      r_op_count   <= '0;
    end else begin
      r_resp_valid <= '0;
      if (w_load) begin
        r_add_a    <= a_in[int'(w_winner)*WIDTH +: WIDTH];
        r_add_b    <= b_in[int'(w_winner)*WIDTH +: WIDTH];
        r_grant_id <= w_winner;
        r_last_id  <= w_winner;
      end
      if (r_state == ST_START) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_deliver) begin
        r_resp_sum   <= add_out;
        r_resp_valid <= NUM_REQ'(1) << r_grant_id;
        r_op_count   <= r_op_count + 16'd1;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_sum   = r_resp_sum;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state != ST_IDLE);
  assign op_count   = r_op_count;
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;

endmodule

// File: tb/tb_add_serial_rr_sched.sv
// tb/tb_add_serial_rr_sched.sv - directed self-checking bench for add_serial_rr_sched
module tb_add_serial_rr_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int L       = 9;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_sum;
  logic [1:0]               grant_id;
  logic                     busy;
  logic [15:0]              op_count;
  logic                     add_en;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic [WIDTH-1:0]         add_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [15:0] exp_ops;

  add_serial_rr_sched #(
    .NUM_REQ     (NUM_REQ),
    .WIDTH       (WIDTH),
    .ADD_LATENCY (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .resp_valid (resp_valid),
    .resp_sum   (resp_sum),
    .grant_id   (grant_id),
    .busy       (busy),
    .op_count   (op_count),
    .add_en     (add_en),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_out    (add_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial adder model: final sum appears L-1 edges after it samples add_en in idle,
  // and shows the complement beforehand so an early capture is caught.
  logic [1:0] m_st;
  int         m_k;
  logic [7:0] m_sum;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st    <= 2'd0;
      m_k     <= 0;
      m_sum   <= 8'h00;
      add_out <= 8'h00;
    end else begin
      case (m_st)
        2'd0: if (add_en) begin
          m_st    <= 2'd1;
          m_k     <= 1;
          m_sum   <= 8'(add_a + add_b);
          add_out <= 8'(~(add_a + add_b));
        end
        2'd1: begin
          m_k <= m_k + 1;
          if (m_k == L - 1) begin
            add_out <= m_sum;
            m_st    <= 2'd2;
          end else begin
            add_out <= ~m_sum;
          end
        end
        default: if (!add_en) m_st <= 2'd0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 16'h0000;
  endtask

  task automatic wait_strobe(output int t, output bit seen);
    seen = 1'b0;
    t = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    check("strobe_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
    int en_cnt;
    bit seen;
    @(negedge clk);
    a_in[id*8 +: 8] = a;
    b_in[id*8 +: 8] = b;
    req[id] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_cnt = int'(add_en);
    check("grant_id", 32'(grant_id), 32'(id));
    check("busy", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int j = 1; j <= 40 && !seen; j++) begin
      @(negedge clk);
      en_cnt += int'(add_en);
      if (resp_valid != '0) begin
        seen = 1'b1;
        exp_ops = exp_ops + 16'd1;
        check("latency", 32'(j), 32'(L + 1));
        check("resp_valid", 32'(resp_valid), 32'(1 << id));
        check("resp_sum", 32'(resp_sum), 32'(s));
        check("op_count", 32'(op_count), 32'(exp_ops));
        req[id] = 1'b0;
      end
    end
    check("resp_seen", 32'(seen), 32'd1);
    check("en_cycles", 32'(en_cnt), 32'(L + 1));
  endtask

  int t;
  int tprev;
  int pulses;
  bit seen;
  logic [7:0] sim_exp [4];
  int fair_ord [4];

  initial begin
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    exp_ops = 16'h0000;
    tprev = 0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_add_en", 32'(add_en), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_resp_sum", 32'(resp_sum), 32'd0);
    rst = 1'b0;

    // Single request and overflow cases.
    run_op(0, 8'h12, 8'h34, 8'h46);
    run_op(1, 8'hFF, 8'h01, 8'h00);
    run_op(1, 8'h80, 8'h80, 8'h00);
    run_op(2, 8'h7F, 8'h01, 8'h80);

    // All four requesting right after reset: served 0..3, strobes 11 cycles apart.
    do_reset();
    a_in = {8'h31, 8'h21, 8'h11, 8'h01};
    b_in = {8'h23, 8'h22, 8'h21, 8'h20};
    sim_exp[0] = 8'h21; sim_exp[1] = 8'h32; sim_exp[2] = 8'h43; sim_exp[3] = 8'h54;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(t, seen);
      check("simul_id", 32'(resp_valid), 32'(1 << i));
      check("simul_sum", 32'(resp_sum), 32'(sim_exp[i]));
      if (i > 0) check("simul_gap", 32'(t - tprev), 32'(L + 2));
      tprev = t;
      req[i] = 1'b0;
    end
    check("simul_op_count", 32'(op_count), 32'd4);

    // Fairness: 0 and 2 held continuously alternate.
    do_reset();
    a_in = {8'h00, 8'h10, 8'h00, 8'h01};
    b_in = {8'h00, 8'h20, 8'h00, 8'h02};
    fair_ord[0] = 0; fair_ord[1] = 2; fair_ord[2] = 0; fair_ord[3] = 2;
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(t, seen);
      check("fair_id", 32'(resp_valid), 32'(1 << fair_ord[i]));
      check("fair_sum", 32'(resp_sum), (fair_ord[i] == 0) ? 32'h03 : 32'h30);
      if (i == 3) req = '0;
    end

    // Reset while in WAIT with cnt=4.
    do_reset();
    @(negedge clk);
    a_in[8 +: 8] = 8'h05;
    b_in[8 +: 8] = 8'h06;
    req[1] = 1'b1;
    @(posedge clk);
    repeat (6) @(negedge clk);
    check("wait_cnt", 32'(dut.r_cnt), 32'd4);
    rst = 1'b1;
    req = '0;
    #1;
    check("arst_add_en", 32'(add_en), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_state", 32'(dut.r_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 16'h0000;
    run_op(1, 8'h05, 8'h06, 8'h0B);

    // Request dropped mid-operation: one strobe, no re-grant.
    @(negedge clk);
    a_in[24 +: 8] = 8'h11;
    b_in[24 +: 8] = 8'h22;
    req[3] = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    req[3] = 1'b0;
    wait_strobe(t, seen);
    exp_ops = exp_ops + 16'd1;
    check("drop_valid", 32'(resp_valid), 32'h8);
    check("drop_sum", 32'(resp_sum), 32'h33);
    check("drop_op_count", 32'(op_count), 32'(exp_ops));
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid != '0) pulses++;
    end
    check("drop_no_regrant", 32'(pulses), 32'd0);
    check("drop_idle", 32'(busy), 32'd0);

    // Counter wrap.
    force dut.r_op_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_op_count;
    check("wrap_preload", 32'(op_count), 32'hFFFF);
    exp_ops = 16'hFFFF;
    run_op(0, 8'h01, 8'h01, 8'h02);
    check("wrap_zero", 32'(op_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
